// File: rtl/rgb_led_driver_pkg.sv
// rgb_led_driver_pkg: shared colour-bit indices and FSM state type
// for the RGB LED PWM fade driver.
package rgb_led_driver_pkg;

  localparam int R_IDX = 2;
  localparam int G_IDX = 1;
  localparam int B_IDX = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_t;

endpackage

// File: rtl/rgb_led_driver_if.sv
// rgb_led_driver_if: colour request in, PWM drive + busy out.
// master = light controller side, slave = LED driver side.
interface rgb_led_driver_if;

  logic       on_off;
  logic [2:0] colour;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       busy;

  modport master (
    output on_off, colour,
    input  led_r, led_g, led_b, busy
  );

  modport slave (
    input  on_off, colour,
    output led_r, led_g, led_b, busy
  );

endinterface

// File: rtl/rgb_led_driver_pwm_channel.sv
// pwm_channel: one colour channel; saturating level fade on tick
// plus registered PWM compare. Ports: clk/rst, tick, pwm count, target -> led, at_target.
module pwm_channel #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic [PWM_BITS-1:0] i_target,
  output logic                o_led,
  output logic                o_at_target
);

  localparam logic [PWM_BITS-1:0] MAX_V  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);

  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_next;
  logic                r_led;

  // Gap is compared against STEP first so the add/sub never wraps.
  always_comb begin
    w_next = r_level;
    if (r_level < i_target) begin
      if ((i_target - r_level) <= STEP_V) w_next = i_target;
      else                                w_next = r_level + STEP_V;
    end else if (r_level > i_target) begin
      if ((r_level - i_target) <= STEP_V) w_next = i_target;
      else                                w_next = r_level - STEP_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_led   <= 1'b0;
    end else begin
      if (i_tick) r_level <= w_next;
      // Full level forced high so no one-clock dip at counter wrap.
      r_led <= (r_level == MAX_V) ? 1'b1 : (i_pwm_cnt < r_level);
    end
  end

  assign o_led       = r_led;
  assign o_at_target = (r_level == i_target);

endmodule

// File: rtl/rgb_led_driver.sv
// rgb_led_driver: colour code + on_off -> three fading PWM LED lines.
// Ports: clk, rst (async high), bus (slave: on_off, colour in; led_r/g/b, busy out).
module rgb_led_driver
  import rgb_led_driver_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 1024,
  parameter int STEP     = 8
) (
  input  logic              clk,
  input  logic              rst,
  rgb_led_driver_if.slave   bus
);

  localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX_V    = {PWM_BITS{1'b1}};

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_pwm;
  logic                w_tick;
  logic [PWM_BITS-1:0] w_tgt [3];
  logic [2:0]          w_led;
  logic [2:0]          w_at;
  state_t              r_state;
  state_t              w_next_state;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_pwm <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_pwm <= r_pwm + 1'b1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign w_tgt[gi] = (bus.on_off && bus.colour[gi]) ? MAX_V : '0;

    pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (w_tick),
      .i_pwm_cnt   (r_pwm),
      .i_target    (w_tgt[gi]),
      .o_led       (w_led[gi]),
      .o_at_target (w_at[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:   if (!(&w_at)) w_next_state = FADING;
      FADING: if (&w_at)    w_next_state = IDLE;
    endcase
  end

  assign bus.led_r = w_led[R_IDX];
  assign bus.led_g = w_led[G_IDX];
  assign bus.led_b = w_led[B_IDX];
  assign bus.busy  = (r_state == FADING);

endmodule

// File: tb/tb_rgb_led_driver.sv
// tb_rgb_led_driver: three driver instances (fast fade, STEP=15, slow fade)
// checked every cycle against a level/threshold model, plus pinned sequences.
module tb_rgb_led_driver;

  localparam int MAXL = 15;

  logic       clk;
  logic       rst;
  logic       on_off;
  logic [2:0] colour;

  int p_fd [3] = '{2, 2, 64};
  int p_st [3] = '{4, 15, 8};

  rgb_led_driver_if if0 ();
  rgb_led_driver_if if1 ();
  rgb_led_driver_if if2 ();

  assign if0.on_off = on_off;
  assign if0.colour = colour;
  assign if1.on_off = on_off;
  assign if1.colour = colour;
  assign if2.on_off = on_off;
  assign if2.colour = colour;

  rgb_led_driver #(.PWM_BITS(4), .FADE_DIV(2), .STEP(4)) u_d0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  rgb_led_driver #(.PWM_BITS(4), .FADE_DIV(2), .STEP(15)) u_d1 (
    .clk (clk), .rst (rst), .bus (if1)
  );
  rgb_led_driver #(.PWM_BITS(4), .FADE_DIV(64), .STEP(8)) u_d2 (
    .clk (clk), .rst (rst), .bus (if2)
  );

  logic [2:0] act_led  [3];
  logic       act_busy [3];

  assign act_led[0]  = {if0.led_r, if0.led_g, if0.led_b};
  assign act_led[1]  = {if1.led_r, if1.led_g, if1.led_b};
  assign act_led[2]  = {if2.led_r, if2.led_g, if2.led_b};
  assign act_busy[0] = if0.busy;
  assign act_busy[1] = if1.busy;
  assign act_busy[2] = if2.busy;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: levels per instance/channel, edge count since release.
  int lvl [3][3];
  int cnt;
  int exp_led  [3];
  int exp_busy [3];

  always begin
    @(posedge clk);
    if (rst) begin
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 3; c++) lvl[k][c] = 0;
        exp_led[k]  = 0;
        exp_busy[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int  pwm;
        bit  tick;
        exp_led[k]  = 0;
        exp_busy[k] = 0;
        pwm  = cnt % 16;
        tick = ((cnt % p_fd[k]) == p_fd[k] - 1);
        for (int c = 0; c < 3; c++) begin
          int tgt;
          tgt = (on_off && colour[c]) ? MAXL : 0;
          if (lvl[k][c] == MAXL || pwm < lvl[k][c])
            exp_led[k] = exp_led[k] | (1 << c);
          if (tgt != lvl[k][c]) exp_busy[k] = 1;
          if (tick) begin
            if (lvl[k][c] < tgt)
              lvl[k][c] = (lvl[k][c] + p_st[k] > tgt) ? tgt : lvl[k][c] + p_st[k];
            else if (lvl[k][c] > tgt)
              lvl[k][c] = (lvl[k][c] - p_st[k] < tgt) ? tgt : lvl[k][c] - p_st[k];
          end
        end
      end
      cnt++;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("led k%0d", k), int'(act_led[k]), exp_led[k]);
      chk($sformatf("busy k%0d", k), int'(act_busy[k]), exp_busy[k]);
    end
  end

  // Records the distinct model levels each channel passes through.
  int tr_seq [3][3][8];
  int tr_len [3][3];
  int tr_busy [3];

  task automatic trace(input int n);
    int last [3][3];
    for (int k = 0; k < 3; k++) begin
      tr_busy[k] = 0;
      for (int c = 0; c < 3; c++) begin
        last[k][c]   = lvl[k][c];
        tr_len[k][c] = 0;
      end
    end
    repeat (n) begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (act_busy[k]) tr_busy[k] = 1;
        for (int c = 0; c < 3; c++) begin
          if (lvl[k][c] != last[k][c] && tr_len[k][c] < 8) begin
            tr_seq[k][c][tr_len[k][c]] = lvl[k][c];
            tr_len[k][c]++;
          end
          last[k][c] = lvl[k][c];
        end
      end
    end
  endtask

  task automatic chk_seq(input string nm, input int k, input int c,
                         input int n, input int a, input int b,
                         input int d, input int e);
    int ex [4];
    ex = '{a, b, d, e};
    chk({nm, " len"}, tr_len[k][c], n);
    for (int i = 0; i < n && i < tr_len[k][c]; i++)
      chk($sformatf("%s[%0d]", nm, i), tr_seq[k][c][i], ex[i]);
  endtask

  initial begin
    int hi;
    rst    = 1'b1;
    on_off = 1'b0;
    colour = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    on_off = 1'b1;
    colour = 3'b100;
    rst    = 1'b0;

    // Fade red up from reset.
    trace(10);
    chk_seq("up red k0", 0, 2, 4, 4, 8, 12, 15);
    chk_seq("up green k0", 0, 1, 0, 0, 0, 0, 0);
    chk_seq("up red k1", 1, 2, 1, 15, 0, 0, 0);
    chk("busy seen k0", tr_busy[0], 1);
    chk("busy done k0", int'(act_busy[0]), 0);
    chk("led_r full k0", int'(act_led[0]), 3'b100);

    // Half duty on slow instance held at level 8.
    repeat (59) @(posedge clk);
    #2;
    chk("slow level", lvl[2][2], 8);
    hi = 0;
    repeat (16) begin
      @(posedge clk);
      #2;
      hi += int'(act_led[2][2]);
    end
    chk("duty 8/16", hi, 8);

    // Async reset mid-run.
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async led k%0d", k), int'(act_led[k]), 0);
      chk($sformatf("async busy k%0d", k), int'(act_busy[k]), 0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Retarget red -> green mid-fade.
    repeat (4) @(posedge clk);
    #2;
    chk("mid red k0", lvl[0][2], 8);
    @(negedge clk);
    colour = 3'b010;
    trace(10);
    chk_seq("down red k0", 0, 2, 2, 4, 0, 0, 0);
    chk_seq("up green k0", 0, 1, 4, 4, 8, 12, 15);
    chk_seq("down red k1", 1, 2, 1, 0, 0, 0, 0);
    chk_seq("up green k1", 1, 1, 1, 15, 0, 0, 0);

    // White to full, then fade out with on_off.
    @(negedge clk);
    colour = 3'b111;
    trace(12);
    chk("white busy k0", int'(act_busy[0]), 0);
    chk("white led k0", int'(act_led[0]), 3'b111);
    @(negedge clk);
    on_off = 1'b0;
    trace(12);
    chk_seq("off red k0", 0, 2, 4, 11, 7, 3, 0);
    chk_seq("off blue k0", 0, 0, 4, 11, 7, 3, 0);
    chk_seq("off red k1", 1, 2, 1, 0, 0, 0, 0);
    chk("off busy seen", tr_busy[0], 1);
    chk("off busy k0", int'(act_busy[0]), 0);
    chk("off led k0", int'(act_led[0]), 0);

    // Random colour/on_off changes with occasional reset.
    repeat (400) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 3) == 0) colour = 3'($urandom);
      on_off = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
